// File: rtl/dcache_controller_if.sv
// ============================================================================
// Module      : dcache_controller_if
// Description : Bundle of CPU, data-memory and cache-SRAM signals around the
//               dcache controller. Suffixes are relative to the controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dcache_controller_if #(
    parameter int TAG_W  = 23,
    parameter int IDX_W  = 4,
    parameter int LINE_W = 256
);
    logic [31:0]       cpu_addr_i;
    logic [31:0]       cpu_data_i;
    logic              cpu_MemRead_i;
    logic              cpu_MemWrite_i;
    logic [31:0]       cpu_data_o;
    logic              cpu_stall_o;

    logic [LINE_W-1:0] mem_data_i;
    logic              mem_ack_i;
    logic [31:0]       mem_addr_o;
    logic [LINE_W-1:0] mem_data_o;
    logic              mem_enable_o;
    logic              mem_write_o;

    logic              cache_sram_enable_o;
    logic              cache_sram_write_o;
    logic [IDX_W-1:0]  cache_sram_index_o;
    logic [TAG_W+1:0]  cache_sram_tag_o;
    logic [LINE_W-1:0] cache_sram_data_o;
    logic              cache_sram_hit_i;
    logic [TAG_W+1:0]  cache_sram_tag_i;
    logic [LINE_W-1:0] cache_sram_data_i;

    // master: the controller, which masters both memory and the SRAM.
    modport master (
        input  cpu_addr_i, cpu_data_i, cpu_MemRead_i, cpu_MemWrite_i,
        output cpu_data_o, cpu_stall_o,
        input  mem_data_i, mem_ack_i,
        output mem_addr_o, mem_data_o, mem_enable_o, mem_write_o,
        output cache_sram_enable_o, cache_sram_write_o, cache_sram_index_o,
        output cache_sram_tag_o, cache_sram_data_o,
        input  cache_sram_hit_i, cache_sram_tag_i, cache_sram_data_i
    );

    // slave: the surrounding CPU, data memory and SRAM.
    modport slave (
        output cpu_addr_i, cpu_data_i, cpu_MemRead_i, cpu_MemWrite_i,
        input  cpu_data_o, cpu_stall_o,
        output mem_data_i, mem_ack_i,
        input  mem_addr_o, mem_data_o, mem_enable_o, mem_write_o,
        input  cache_sram_enable_o, cache_sram_write_o, cache_sram_index_o,
        input  cache_sram_tag_o, cache_sram_data_o,
        output cache_sram_hit_i, cache_sram_tag_i, cache_sram_data_i
    );
endinterface

`default_nettype wire

// File: rtl/dcache_controller.sv
// ============================================================================
// Module      : dcache_controller
// Description : Write-back, write-allocate controller for a 2-way dcache;
//               handles hits, victim write-back and line refill.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dcache_controller #(
    parameter int TAG_W  = 23,
    parameter int IDX_W  = 4,
    parameter int LINE_W = 256
) (
    input  wire logic         clk_i,
    input  wire logic         rst_i,
    dcache_controller_if.master bus
);
    localparam int c_OFF_W  = $clog2(LINE_W / 8);
    localparam int c_WORD_W = c_OFF_W - 2;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_MISS       = 3'd1,
        S_WRITEBACK  = 3'd2,
        S_WB_DONE    = 3'd3,
        S_READMISS   = 3'd4,
        S_READMISSOK = 3'd5
    } state_t;

    state_t              r_state;
    logic [31:0]         r_mem_addr;
    logic [LINE_W-1:0]   r_victim_data;
    logic [LINE_W-1:0]   r_fill;

    logic                w_req;
    logic                w_store;
    logic                w_hit_idle;
    logic [TAG_W-1:0]    w_tag;
    logic [IDX_W-1:0]    w_index;
    logic [c_WORD_W-1:0] w_word;
    logic [LINE_W-1:0]   w_merged;
    logic                w_victim_dirty;
    logic                w_unused_ok;

    assign w_req          = bus.cpu_MemRead_i | bus.cpu_MemWrite_i;
    assign w_store        = bus.cpu_MemWrite_i;
    assign w_tag          = bus.cpu_addr_i[31 -: TAG_W];
    assign w_index        = bus.cpu_addr_i[c_OFF_W +: IDX_W];
    assign w_word         = bus.cpu_addr_i[c_OFF_W-1:2];
    assign w_hit_idle     = (r_state == S_IDLE) & bus.cache_sram_hit_i;
    assign w_victim_dirty = bus.cache_sram_tag_i[TAG_W+1] & bus.cache_sram_tag_i[TAG_W];
    assign w_unused_ok    = &{1'b0, bus.cpu_addr_i[1:0]};

    assign bus.cpu_stall_o        = w_req & ~w_hit_idle;
    assign bus.cpu_data_o         = bus.cache_sram_data_i[{w_word, 5'b00000} +: 32];
    assign bus.cache_sram_index_o = w_index;

    assign bus.mem_enable_o = (r_state == S_WRITEBACK) | (r_state == S_READMISS);
    assign bus.mem_write_o  = (r_state == S_WRITEBACK);
    assign bus.mem_addr_o   = r_mem_addr;
    assign bus.mem_data_o   = r_victim_data;

    always_comb begin
        w_merged = bus.cache_sram_data_i;
        w_merged[{w_word, 5'b00000} +: 32] = bus.cpu_data_i;
    end

    // SRAM strobes: hit accesses in IDLE, line install in READMISSOK.
    always_comb begin
        bus.cache_sram_enable_o = 1'b0;
        bus.cache_sram_write_o  = 1'b0;
        bus.cache_sram_tag_o    = {1'b1, 1'b0, w_tag};
        bus.cache_sram_data_o   = r_fill;
        case (r_state)
            S_IDLE: begin
                if (w_req & bus.cache_sram_hit_i) begin
                    bus.cache_sram_enable_o = 1'b1;
                    if (w_store) begin
                        bus.cache_sram_write_o = 1'b1;
                        bus.cache_sram_tag_o   = {1'b1, 1'b1, w_tag};
                        bus.cache_sram_data_o  = w_merged;
                    end
                end
            end
            S_READMISSOK: begin
                bus.cache_sram_enable_o = 1'b1;
                bus.cache_sram_write_o  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state       <= S_IDLE;
            r_mem_addr    <= '0;
            r_victim_data <= '0;
            r_fill        <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req & ~bus.cache_sram_hit_i) r_state <= S_MISS;
                end
                S_MISS: begin
                    // The victim tag lives on as the write-back address.
                    r_victim_data <= bus.cache_sram_data_i;
                    if (w_victim_dirty) begin
                        r_mem_addr <= {bus.cache_sram_tag_i[TAG_W-1:0], w_index, {c_OFF_W{1'b0}}};
                        r_state    <= S_WRITEBACK;
                    end else begin
                        r_mem_addr <= {w_tag, w_index, {c_OFF_W{1'b0}}};
                        r_state    <= S_READMISS;
                    end
                end
                S_WRITEBACK: begin
                    if (bus.mem_ack_i) r_state <= S_WB_DONE;
                end
                S_WB_DONE: begin
                    r_mem_addr <= {w_tag, w_index, {c_OFF_W{1'b0}}};
                    r_state    <= S_READMISS;
                end
                S_READMISS: begin
                    if (bus.mem_ack_i) begin
                        r_fill  <= bus.mem_data_i;
                        r_state <= S_READMISSOK;
                    end
                end
                S_READMISSOK: r_state <= S_IDLE;
                default:      r_state <= S_IDLE;
            endcase
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_dcache_controller.sv
// ============================================================================
// Module      : tb_dcache_controller
// Description : Directed bench for dcache_controller with a 2-way LRU SRAM
//               model and a data memory that acks in its 10th enable cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dcache_controller;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dcache_controller_if bus ();
    dcache_controller dut (.clk_i(clk), .rst_i(rst_n), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;

    function automatic logic [255:0] pattern(input logic [31:0] a);
        logic [255:0] l;
        for (int j = 0; j < 8; j++) l[j*32 +: 32] = (a ^ 32'hC0DE_0000) + 32'h0101_0101 * 32'(j);
        return l;
    endfunction

    function automatic logic [255:0] merge(input logic [255:0] l, input int w, input logic [31:0] d);
        logic [255:0] r;
        r = l;
        r[w*32 +: 32] = d;
        return r;
    endfunction

    function automatic logic [31:0] wrd(input logic [255:0] l, input int w);
        return l[w*32 +: 32];
    endfunction

    // ---------------- data memory model ----------------
    logic [255:0] mem_store [logic [31:0]];
    int           m_cnt = 0;
    int           wb_cnt = 0, fetch_cnt = 0;
    logic [31:0]  wb_addr = '0, fetch_addr = '0;
    logic [255:0] wb_data = '0;

    function automatic logic [255:0] mem_line(input logic [31:0] a);
        if (mem_store.exists(a)) return mem_store[a];
        return pattern(a);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt         <= 0;
            bus.mem_ack_i <= 1'b0;
        end else begin
            bus.mem_ack_i <= 1'b0;
            if (bus.mem_enable_o && !bus.mem_ack_i) begin
                if (m_cnt == 8) begin
                    m_cnt         <= 0;
                    bus.mem_ack_i <= 1'b1;
                    if (bus.mem_write_o) begin
                        wb_cnt  <= wb_cnt + 1;
                        wb_addr <= bus.mem_addr_o;
                        wb_data <= bus.mem_data_o;
                        mem_store[bus.mem_addr_o] = bus.mem_data_o;
                    end else begin
                        fetch_cnt      <= fetch_cnt + 1;
                        fetch_addr     <= bus.mem_addr_o;
                        bus.mem_data_i <= mem_line(bus.mem_addr_o);
                    end
                end else begin
                    m_cnt <= m_cnt + 1;
                end
            end
        end
    end

    // ---------------- 2-way SRAM model, cleared by reset ----------------
    logic [24:0]  s_tag  [16][2];
    logic [255:0] s_data [16][2];
    logic         s_lru  [16];
    logic [24:0]  last_wtag = '0;
    logic [3:0]   idx;
    logic         m_h0, m_h1, m_way;

    assign idx = bus.cache_sram_index_o;

    always_comb begin
        m_h0  = s_tag[idx][0][24] && (s_tag[idx][0][22:0] == bus.cpu_addr_i[31:9]);
        m_h1  = s_tag[idx][1][24] && (s_tag[idx][1][22:0] == bus.cpu_addr_i[31:9]);
        m_way = m_h0 ? 1'b0 : (m_h1 ? 1'b1 : s_lru[idx]);
        bus.cache_sram_hit_i  = m_h0 | m_h1;
        bus.cache_sram_tag_i  = s_tag[idx][m_way];
        bus.cache_sram_data_i = s_data[idx][m_way];
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < 16; s++) begin
                s_lru[s] <= 1'b0;
                for (int w = 0; w < 2; w++) begin
                    s_tag[s][w]  <= '0;
                    s_data[s][w] <= '0;
                end
            end
        end else if (bus.cache_sram_enable_o) begin
            if (bus.cache_sram_write_o) begin
                s_tag[idx][m_way]  <= bus.cache_sram_tag_o;
                s_data[idx][m_way] <= bus.cache_sram_data_o;
                last_wtag          <= bus.cache_sram_tag_o;
            end
            s_lru[idx] <= ~m_way;
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    logic         cap_en, cap_wr;
    logic [24:0]  cap_tag;
    logic [255:0] cap_line;
    logic [31:0]  cap_rdata;

    // Entered and left at a falling edge; counts cycles with stall high.
    task automatic run_req(input logic [31:0] a, input logic [31:0] d, input logic rd, input logic wr,
                           output int stall, output int gap, output logic tmo);
        int first, last, hi;
        bus.cpu_addr_i     = a;
        bus.cpu_data_i     = d;
        bus.cpu_MemRead_i  = rd;
        bus.cpu_MemWrite_i = wr;
        stall = 0; first = -1; last = -1; hi = 0; tmo = 1'b0;
        #1;
        while (bus.cpu_stall_o !== 1'b0) begin
            if (bus.mem_enable_o === 1'b1) begin
                if (first < 0) first = stall;
                last = stall;
                hi++;
            end
            stall++;
            if (stall > 200) begin
                tmo = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
        cap_en    = bus.cache_sram_enable_o;
        cap_wr    = bus.cache_sram_write_o;
        cap_tag   = bus.cache_sram_tag_o;
        cap_line  = bus.cache_sram_data_o;
        cap_rdata = bus.cpu_data_o;
        gap = (first < 0) ? 0 : (last - first + 1 - hi);
        @(negedge clk);
        bus.cpu_MemRead_i  = 1'b0;
        bus.cpu_MemWrite_i = 1'b0;
    endtask

    typedef struct {
        logic [31:0]  addr;
        logic [31:0]  wdata;
        logic         rd;
        logic         wr;
        int           exp_stall;
        logic         exp_write;
        logic [24:0]  exp_tag;
        logic [31:0]  exp_rdata;
        logic [255:0] exp_line;
        int           exp_wb;
        logic [31:0]  exp_wb_addr;
        logic [255:0] exp_wb_data;
        int           exp_fetch;
        logic [31:0]  exp_fetch_addr;
    } vec_t;

    function automatic vec_t mk(logic [31:0] a, logic [31:0] d, logic rd, logic wr, int st,
                                logic ew, logic [24:0] et, logic [31:0] er, logic [255:0] el,
                                int wb, logic [31:0] wa, logic [255:0] wd, int f, logic [31:0] fa);
        vec_t v;
        v.addr = a; v.wdata = d; v.rd = rd; v.wr = wr; v.exp_stall = st;
        v.exp_write = ew; v.exp_tag = et; v.exp_rdata = er; v.exp_line = el;
        v.exp_wb = wb; v.exp_wb_addr = wa; v.exp_wb_data = wd;
        v.exp_fetch = f; v.exp_fetch_addr = fa;
        return v;
    endfunction

    vec_t vecs [11];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] l1, m1, l2, l4, m5, l6, m10;
        int           stall, gap, wb0, f0;
        logic         tmo;

        l1  = pattern(32'h0000_0100);
        m1  = merge(l1, 1, 32'hDEAD_BEEF);
        l2  = pattern(32'h0000_2100);
        l4  = pattern(32'h0000_4100);
        m5  = merge(l4, 2, 32'h1234_5678);
        l6  = pattern(32'h0000_6100);
        m10 = merge(m1, 0, 32'hCAFE_F00D);

        //              addr          wdata         rd wr st  wr tag          rdata            line wb wbaddr        wbdata f fetch
        vecs[0]  = mk(32'h0000_0104, 32'h0,        1, 0, 13, 0, 25'h0,       wrd(l1, 1),      '0,  0, 32'h0,        '0, 1, 32'h0000_0100);
        vecs[1]  = mk(32'h0000_0104, 32'hDEADBEEF, 0, 1,  0, 1, 25'h1800000, 32'h0,           m1,  0, 32'h0,        '0, 0, 32'h0);
        vecs[2]  = mk(32'h0000_2104, 32'h0,        1, 0, 13, 0, 25'h0,       wrd(l2, 1),      '0,  0, 32'h0,        '0, 1, 32'h0000_2100);
        vecs[3]  = mk(32'h0000_2104, 32'h0,        1, 0,  0, 0, 25'h0,       wrd(l2, 1),      '0,  0, 32'h0,        '0, 0, 32'h0);
        vecs[4]  = mk(32'h0000_4104, 32'h0,        1, 0, 24, 0, 25'h0,       wrd(l4, 1),      '0,  1, 32'h0000_0100, m1, 1, 32'h0000_4100);
        vecs[5]  = mk(32'h0000_4108, 32'h12345678, 1, 1,  0, 1, 25'h1800020, 32'h0,           m5,  0, 32'h0,        '0, 0, 32'h0);
        vecs[6]  = mk(32'h0000_4108, 32'h0,        1, 0,  0, 0, 25'h0,       32'h1234_5678,   '0,  0, 32'h0,        '0, 0, 32'h0);
        vecs[7]  = mk(32'h0000_6104, 32'h0,        1, 0, 13, 0, 25'h0,       wrd(l6, 1),      '0,  0, 32'h0,        '0, 1, 32'h0000_6100);
        vecs[8]  = mk(32'h0000_0104, 32'h0,        1, 0, 24, 0, 25'h0,       32'hDEAD_BEEF,   '0,  1, 32'h0000_4100, m5, 1, 32'h0000_0100);
        vecs[9]  = mk(32'h0000_011C, 32'h0,        1, 0,  0, 0, 25'h0,       wrd(l1, 7),      '0,  0, 32'h0,        '0, 0, 32'h0);
        vecs[10] = mk(32'h0000_0100, 32'hCAFEF00D, 0, 1,  0, 1, 25'h1800000, 32'h0,           m10, 0, 32'h0,        '0, 0, 32'h0);

        bus.cpu_addr_i     = '0;
        bus.cpu_data_i     = '0;
        bus.cpu_MemRead_i  = 1'b0;
        bus.cpu_MemWrite_i = 1'b0;
        repeat (3) @(negedge clk);

        check("reset mem_enable", bus.mem_enable_o, 1'b0);
        check("reset mem_write", bus.mem_write_o, 1'b0);
        check("reset sram_enable", bus.cache_sram_enable_o, 1'b0);
        check("reset sram_write", bus.cache_sram_write_o, 1'b0);
        check("reset stall", bus.cpu_stall_o, 1'b0);
        check("reset mem_addr", bus.mem_addr_o, 32'h0);
        check("reset mem_data", bus.mem_data_o, 256'h0);

        // Reset in the middle of a line fetch, then restart the same load.
        rst_n = 1'b1;
        @(negedge clk);
        bus.cpu_addr_i    = 32'h0000_0100;
        bus.cpu_MemRead_i = 1'b1;
        repeat (4) @(negedge clk);
        check("pre-reset mem_enable", bus.mem_enable_o, 1'b1);
        rst_n = 1'b0;
        #1;
        check("async reset mem_enable", bus.mem_enable_o, 1'b0);
        check("async reset sram_enable", bus.cache_sram_enable_o, 1'b0);
        check("async reset stall held", bus.cpu_stall_o, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        f0 = fetch_cnt;
        run_req(32'h0000_0100, 32'h0, 1'b1, 1'b0, stall, gap, tmo);
        check("restart timeout", tmo, 1'b0);
        check("restart stall", stall, 13);
        check("restart rdata", cap_rdata, wrd(l1, 0));
        check("restart fetch count", fetch_cnt - f0, 1);
        check("restart fetch addr", fetch_addr, 32'h0000_0100);

        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            wb0 = wb_cnt;
            f0  = fetch_cnt;
            run_req(vecs[i].addr, vecs[i].wdata, vecs[i].rd, vecs[i].wr, stall, gap, tmo);
            check($sformatf("v%0d timeout", i), tmo, 1'b0);
            check($sformatf("v%0d stall", i), stall, vecs[i].exp_stall);
            check($sformatf("v%0d sram_enable", i), cap_en, 1'b1);
            check($sformatf("v%0d sram_write", i), cap_wr, vecs[i].exp_write);
            if (vecs[i].exp_write) begin
                check($sformatf("v%0d sram_tag", i), cap_tag, vecs[i].exp_tag);
                check($sformatf("v%0d sram_data", i), cap_line, vecs[i].exp_line);
            end else begin
                check($sformatf("v%0d cpu_data", i), cap_rdata, vecs[i].exp_rdata);
            end
            check($sformatf("v%0d wb count", i), wb_cnt - wb0, vecs[i].exp_wb);
            check($sformatf("v%0d fetch count", i), fetch_cnt - f0, vecs[i].exp_fetch);
            if (vecs[i].exp_wb != 0) begin
                check($sformatf("v%0d wb addr", i), wb_addr, vecs[i].exp_wb_addr);
                check($sformatf("v%0d wb data", i), wb_data, vecs[i].exp_wb_data);
                check($sformatf("v%0d enable gap", i), gap, 1);
            end
            if (vecs[i].exp_fetch != 0) begin
                check($sformatf("v%0d fetch addr", i), fetch_addr, vecs[i].exp_fetch_addr);
                check($sformatf("v%0d fill tag", i), last_wtag, {2'b10, vecs[i].addr[31:9]});
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
